// File: rtl/halfband_chan_sched.sv
// halfband_chan_sched: shares one AXI-stream halfband filter between two PCM
// channels. Samples are held per channel, issued round-robin, tagged with
// their channel id, and the filter results are routed back through a tag
// FIFO and saturated from 32 to 24 bits.
module halfband_chan_sched #(
  parameter int OUT_PER_IN = 2,
  parameter int TAG_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_valid,
  input  logic [23:0] ch0_data,
  input  logic        ch1_valid,
  input  logic [23:0] ch1_data,
  output logic        flt_tvalid,
  input  logic        flt_tready,
  output logic [23:0] flt_tdata,
  input  logic        flt_out_valid,
  input  logic [31:0] flt_out_data,
  output logic [23:0] ch0_out,
  output logic        ch0_out_valid,
  output logic [23:0] ch1_out,
  output logic        ch1_out_valid,
  input  logic        clear_flags,
  output logic [1:0]  overrun,
  output logic [1:0]  sat_hit,
  output logic        orphan
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = (OUT_PER_IN > 1) ? $clog2(OUT_PER_IN) : 1;
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(TAG_DEPTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(OUT_PER_IN - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   rr_q, rr_d;
  logic                   tvalid_q, tvalid_d;
  logic [23:0]            tdata_q, tdata_d;
  logic [1:0][23:0]       hold_q, hold_d;
  logic [1:0]             full_q, full_d;
  logic [TAG_DEPTH-1:0]   tag_mem_q, tag_mem_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;
  logic [CW-1:0]          beat_q, beat_d;
  logic [23:0]            ch0_out_q, ch0_out_d, ch1_out_q, ch1_out_d;
  logic                   ch0_out_valid_q, ch0_out_valid_d;
  logic                   ch1_out_valid_q, ch1_out_valid_d;
  logic [1:0]             overrun_q, overrun_d, sat_hit_q, sat_hit_d;
  logic                   orphan_q, orphan_d;

  logic                   hs, push, pop, head, clip, orphan_set;
  logic [1:0]             in_valid, ovr_set, sat_set;
  logic [1:0][23:0]       in_data;
  logic [23:0]            sat_val;

  assign hs       = tvalid_q & flt_tready;
  assign push     = hs;
  assign pop      = flt_out_valid && (count_q != '0) && (beat_q == LAST_BEAT);
  assign head     = tag_mem_q[rd_ptr_q];
  assign in_valid = {ch1_valid, ch0_valid};
  assign in_data  = {ch1_data, ch0_data};

  // Signed clip of the 32-bit filter result into the 24-bit output range
  always_comb begin
    sat_val = flt_out_data[23:0];
    clip    = 1'b0;
    if ($signed(flt_out_data) > 32'sd8388607) begin
      sat_val = 24'h7FFFFF;
      clip    = 1'b1;
    end else if ($signed(flt_out_data) < -32'sd8388608) begin
      sat_val = 24'h800000;
      clip    = 1'b1;
    end
  end

  // Next-state logic: holding regs, issue FSM, tag FIFO, return path, flags
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    tvalid_d        = tvalid_q;
    tdata_d         = tdata_q;
    hold_d          = hold_q;
    full_d          = full_q;
    tag_mem_d       = tag_mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    beat_d          = beat_q;
    ch0_out_d       = ch0_out_q;
    ch1_out_d       = ch1_out_q;
    ch0_out_valid_d = 1'b0;
    ch1_out_valid_d = 1'b0;
    ovr_set         = 2'b00;
    sat_set         = 2'b00;
    orphan_set      = 1'b0;

    // A sample landing in its own handshake cycle refills the slot being freed
    for (int n = 0; n < 2; n++) begin
      if (in_valid[n]) begin
        if (!full_q[n] || (hs && grant_q == 1'(n))) begin
          hold_d[n] = in_data[n];
          full_d[n] = 1'b1;
        end else begin
          ovr_set[n] = 1'b1;
        end
      end else if (hs && grant_q == 1'(n)) begin
        full_d[n] = 1'b0;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_q;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if ((full_q != 2'b00) && (count_q < DEPTH_C)) begin
          grant_d  = (&full_q) ? rr_q : full_q[1];
          tdata_d  = hold_q[(&full_q) ? rr_q : full_q[1]];
          tvalid_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          rr_d = ~grant_q;
          if (full_q[~grant_q] && (count_d < DEPTH_C)) begin
            grant_d = ~grant_q;
            tdata_d = hold_q[~grant_q];
          end else begin
            tvalid_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flt_out_valid) begin
      if (count_q == '0) begin
        orphan_set = 1'b1;
      end else begin
        if (head) begin
          ch1_out_d       = sat_val;
          ch1_out_valid_d = 1'b1;
        end else begin
          ch0_out_d       = sat_val;
          ch0_out_valid_d = 1'b1;
        end
        sat_set[head] = clip;
        if (beat_q == LAST_BEAT) begin
          beat_d   = '0;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    end

    overrun_d = clear_flags ? 2'b00 : (overrun_q | ovr_set);
    sat_hit_d = clear_flags ? 2'b00 : (sat_hit_q | sat_set);
    orphan_d  = clear_flags ? 1'b0  : (orphan_q | orphan_set);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= 1'b0;
      rr_q            <= 1'b0;
      tvalid_q        <= 1'b0;
      tdata_q         <= '0;
      hold_q          <= '0;
      full_q          <= '0;
      tag_mem_q       <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      beat_q          <= '0;
      ch0_out_q       <= '0;
      ch1_out_q       <= '0;
      ch0_out_valid_q <= 1'b0;
      ch1_out_valid_q <= 1'b0;
      overrun_q       <= '0;
      sat_hit_q       <= '0;
      orphan_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      rr_q            <= rr_d;
      tvalid_q        <= tvalid_d;
      tdata_q         <= tdata_d;
      hold_q          <= hold_d;
      full_q          <= full_d;
      tag_mem_q       <= tag_mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      beat_q          <= beat_d;
      ch0_out_q       <= ch0_out_d;
      ch1_out_q       <= ch1_out_d;
      ch0_out_valid_q <= ch0_out_valid_d;
      ch1_out_valid_q <= ch1_out_valid_d;
      overrun_q       <= overrun_d;
      sat_hit_q       <= sat_hit_d;
      orphan_q        <= orphan_d;
    end
  end

  assign flt_tvalid    = tvalid_q;
  assign flt_tdata     = tdata_q;
  assign ch0_out       = ch0_out_q;
  assign ch1_out       = ch1_out_q;
  assign ch0_out_valid = ch0_out_valid_q;
  assign ch1_out_valid = ch1_out_valid_q;
  assign overrun       = overrun_q;
  assign sat_hit       = sat_hit_q;
  assign orphan        = orphan_q;

endmodule

// File: tb/tb_halfband_chan_sched.sv
// Directed testbench for halfband_chan_sched (OUT_PER_IN=2, TAG_DEPTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_halfband_chan_sched;

  logic        clk;
  logic        rst;
  logic        ch0_valid, ch1_valid;
  logic [23:0] ch0_data, ch1_data;
  logic        flt_tvalid, flt_tready;
  logic [23:0] flt_tdata;
  logic        flt_out_valid;
  logic [31:0] flt_out_data;
  logic [23:0] ch0_out, ch1_out;
  logic        ch0_out_valid, ch1_out_valid;
  logic        clear_flags;
  logic [1:0]  overrun, sat_hit;
  logic        orphan;

  int checks = 0;
  int errors = 0;

  logic [31:0] beat_data [4];
  logic        beat_ch   [4];
  logic [23:0] beat_exp  [4];

  halfband_chan_sched #(.OUT_PER_IN(2), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .ch0_valid(ch0_valid), .ch0_data(ch0_data),
    .ch1_valid(ch1_valid), .ch1_data(ch1_data),
    .flt_tvalid(flt_tvalid), .flt_tready(flt_tready), .flt_tdata(flt_tdata),
    .flt_out_valid(flt_out_valid), .flt_out_data(flt_out_data),
    .ch0_out(ch0_out), .ch0_out_valid(ch0_out_valid),
    .ch1_out(ch1_out), .ch1_out_valid(ch1_out_valid),
    .clear_flags(clear_flags),
    .overrun(overrun), .sat_hit(sat_hit), .orphan(orphan)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock cycles with the inputs currently applied
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    rst = 1'b1; ch0_valid = 1'b0; ch1_valid = 1'b0; ch0_data = '0; ch1_data = '0;
    flt_tready = 1'b0; flt_out_valid = 1'b0; flt_out_data = '0; clear_flags = 1'b0;
    applyStimulus(2);
    checkOutput("rst_tvalid", 32'(flt_tvalid), 32'd0);
    checkOutput("rst_ch0_valid", 32'(ch0_out_valid), 32'd0);
    checkOutput("rst_ch0_out", 32'(ch0_out), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_sat_hit", 32'(sat_hit), 32'd0);
    checkOutput("rst_orphan", 32'(orphan), 32'd0);
    rst = 1'b0;

    $display("[TB] single ch0 sample with two output beats");
    flt_tready = 1'b1; ch0_valid = 1'b1; ch0_data = 24'h000123;
    applyStimulus(1); ch0_valid = 1'b0;
    checkOutput("t1_tvalid_load", 32'(flt_tvalid), 32'd0);
    applyStimulus(1);
    checkOutput("t1_tvalid", 32'(flt_tvalid), 32'd1);
    checkOutput("t1_tdata", 32'(flt_tdata), 32'h000123);
    applyStimulus(1);
    checkOutput("t1_tvalid_done", 32'(flt_tvalid), 32'd0);
    flt_out_valid = 1'b1; flt_out_data = 32'h00000456;
    applyStimulus(1); flt_out_valid = 1'b0;
    checkOutput("t1_b0_ch0_valid", 32'(ch0_out_valid), 32'd1);
    checkOutput("t1_b0_ch0_out", 32'(ch0_out), 32'h000456);
    checkOutput("t1_b0_ch1_valid", 32'(ch1_out_valid), 32'd0);
    applyStimulus(1);
    checkOutput("t1_strobe_low", 32'(ch0_out_valid), 32'd0);
    flt_out_valid = 1'b1;
    applyStimulus(1); flt_out_valid = 1'b0;
    checkOutput("t1_b1_ch0_valid", 32'(ch0_out_valid), 32'd1);
    checkOutput("t1_b1_ch0_out", 32'(ch0_out), 32'h000456);
    applyStimulus(1);
    checkOutput("t1_orphan", 32'(orphan), 32'd0);

    $display("[TB] simultaneous samples, back-to-back issue");
    rst = 1'b1; applyStimulus(1); rst = 1'b0;
    ch0_valid = 1'b1; ch0_data = 24'h0000AA; ch1_valid = 1'b1; ch1_data = 24'h0000BB;
    applyStimulus(1); ch0_valid = 1'b0; ch1_valid = 1'b0;
    applyStimulus(1);
    checkOutput("t2_first_tvalid", 32'(flt_tvalid), 32'd1);
    checkOutput("t2_first_tdata", 32'(flt_tdata), 32'h0000AA);
    applyStimulus(1);
    checkOutput("t2_second_tvalid", 32'(flt_tvalid), 32'd1);
    checkOutput("t2_second_tdata", 32'(flt_tdata), 32'h0000BB);
    applyStimulus(1);
    checkOutput("t2_idle_tvalid", 32'(flt_tvalid), 32'd0);
    beat_data = '{32'h10, 32'h11, 32'h20, 32'h21};
    beat_ch   = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      flt_out_valid = 1'b1; flt_out_data = beat_data[k];
      applyStimulus(1);
      checkOutput($sformatf("t2_beat%0d_ch0_valid", k), 32'(ch0_out_valid), 32'(!beat_ch[k]));
      checkOutput($sformatf("t2_beat%0d_ch1_valid", k), 32'(ch1_out_valid), 32'(beat_ch[k]));
      checkOutput($sformatf("t2_beat%0d_data", k), 32'(beat_ch[k] ? ch1_out : ch0_out),
                  32'(beat_data[k][23:0]));
    end
    flt_out_valid = 1'b0;

    $display("[TB] backpressure hold and overrun");
    flt_tready = 1'b0;
    ch0_valid = 1'b1; ch0_data = 24'h111111; ch1_valid = 1'b1; ch1_data = 24'h222222;
    applyStimulus(1); ch0_valid = 1'b0; ch1_valid = 1'b0;
    applyStimulus(1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        ch0_valid = 1'b1; ch0_data = 24'h333333;
      end
      applyStimulus(1); ch0_valid = 1'b0;
      checkOutput($sformatf("t3_hold%0d_tvalid", i), 32'(flt_tvalid), 32'd1);
      checkOutput($sformatf("t3_hold%0d_tdata", i), 32'(flt_tdata), 32'h111111);
    end
    checkOutput("t3_overrun", 32'(overrun), 32'd1);
    flt_tready = 1'b1;
    applyStimulus(1);
    checkOutput("t3_ch1_tvalid", 32'(flt_tvalid), 32'd1);
    checkOutput("t3_ch1_tdata", 32'(flt_tdata), 32'h222222);
    applyStimulus(1);
    checkOutput("t3_idle_tvalid", 32'(flt_tvalid), 32'd0);
    applyStimulus(1);
    checkOutput("t3_no_reissue", 32'(flt_tvalid), 32'd0);

    $display("[TB] saturation boundaries and flag clear");
    beat_data = '{32'h007FFFFF, 32'hFF800000, 32'h00900000, 32'hFF000000};
    beat_exp  = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000};
    for (int k = 0; k < 4; k++) begin
      flt_out_valid = 1'b1; flt_out_data = beat_data[k];
      applyStimulus(1);
      checkOutput($sformatf("t4_beat%0d_valid", k), 32'(beat_ch[k] ? ch1_out_valid : ch0_out_valid), 32'd1);
      checkOutput($sformatf("t4_beat%0d_data", k), 32'(beat_ch[k] ? ch1_out : ch0_out), 32'(beat_exp[k]));
      checkOutput($sformatf("t4_beat%0d_sat_hit", k), 32'(sat_hit), (k < 2) ? 32'd0 : 32'd2);
    end
    flt_out_valid = 1'b0;
    clear_flags = 1'b1;
    applyStimulus(1); clear_flags = 1'b0;
    checkOutput("t4_sat_cleared", 32'(sat_hit), 32'd0);
    checkOutput("t4_overrun_cleared", 32'(overrun), 32'd0);

    $display("[TB] tag FIFO full stalls issue");
    for (int i = 0; i < 8; i++) begin
      ch0_valid = 1'b1; ch0_data = 24'(i);
      applyStimulus(1); ch0_valid = 1'b0;
      applyStimulus(2);
    end
    ch0_valid = 1'b1; ch0_data = 24'h0000AB;
    applyStimulus(1); ch0_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("t5_full%0d_tvalid", i), 32'(flt_tvalid), 32'd0);
    end
    flt_out_valid = 1'b1; flt_out_data = 32'h00000007;
    applyStimulus(2); flt_out_valid = 1'b0;
    checkOutput("t5_pop_edge_tvalid", 32'(flt_tvalid), 32'd0);
    checkOutput("t5_pop_ch0_out", 32'(ch0_out), 32'h000007);
    applyStimulus(1);
    checkOutput("t5_resume_tvalid", 32'(flt_tvalid), 32'd1);
    checkOutput("t5_resume_tdata", 32'(flt_tdata), 32'h0000AB);
    applyStimulus(1);

    $display("[TB] reset with tags in flight");
    rst = 1'b1; applyStimulus(1); rst = 1'b0;
    checkOutput("t6_rst_tvalid", 32'(flt_tvalid), 32'd0);
    checkOutput("t6_rst_orphan", 32'(orphan), 32'd0);
    flt_out_valid = 1'b1; flt_out_data = 32'h00001234;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("t6_beat%0d_ch0_valid", i), 32'(ch0_out_valid), 32'd0);
      checkOutput($sformatf("t6_beat%0d_ch1_valid", i), 32'(ch1_out_valid), 32'd0);
      checkOutput($sformatf("t6_beat%0d_orphan", i), 32'(orphan), 32'd1);
    end
    clear_flags = 1'b1;
    applyStimulus(1); clear_flags = 1'b0; flt_out_valid = 1'b0;
    checkOutput("t6_clear_priority", 32'(orphan), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
